// File: rtl/seq_mult_pkg.sv
// Shared types and sizing helpers for the sequential shift-add multiplier.
// The state enum and the counter width are kept here so sub-blocks and benches agree.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MIN_WIDTH = 2;
  localparam int MAX_WIDTH = 16;

  // Counter must be able to hold WIDTH itself, not just WIDTH-1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_multiplier_if.sv
// Start/done handshake bundle between a controller (master) and the multiplier (slave).
interface seq_multiplier_if #(
  parameter int WIDTH = 4
);

  logic                   start;
  logic                   signed_mode;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic                   busy;
  logic                   done;
  logic [2*WIDTH-1:0]     p;

  modport master (
    output start, signed_mode, a, b,
    input  busy, done, p
  );

  modport slave (
    input  start, signed_mode, a, b,
    output busy, done, p
  );

endinterface

// File: rtl/seq_multiplier_abs_neg.sv
// Width-parameterised conditional two's-complement negate; used both for operand
// magnitudes and for restoring the sign of the finished product.
module abs_neg #(
  parameter int W = 4
) (
  input  logic [W-1:0] in_val,
  input  logic         neg,
  output logic [W-1:0] out_val
);

  assign out_val = neg ? (~in_val + W'(1)) : in_val;

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: one multiplier bit per clock, WIDTH clocks per product,
// unsigned or two's-complement operands selected per operation.
module seq_multiplier
  import seq_mult_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  seq_multiplier_if.slave   bus
);

  localparam int CW = cnt_width(WIDTH);

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   acc_shift;
  logic [2*WIDTH-1:0]   p_fix;

  abs_neg #(.W(WIDTH)) u_abs_a (
    .in_val  (bus.a),
    .neg     (bus.signed_mode & bus.a[WIDTH-1]),
    .out_val (a_mag)
  );

  abs_neg #(.W(WIDTH)) u_abs_b (
    .in_val  (bus.b),
    .neg     (bus.signed_mode & bus.b[WIDTH-1]),
    .out_val (b_mag)
  );

  // The extra adder bit keeps the carry, which lands in the accumulator MSB after the shift.
  assign sum       = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (mplier_q[0] ? mcand_q : '0)};
  assign acc_shift = {sum, acc_q[WIDTH-1:1]};

  abs_neg #(.W(2*WIDTH)) u_fix (
    .in_val  (acc_shift),
    .neg     (neg_q & (acc_shift != '0)),
    .out_val (p_fix)
  );

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    p_d      = p_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          mcand_d  = a_mag;
          mplier_d = b_mag;
          neg_d    = bus.signed_mode & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = CALC;
          busy_d   = 1'b1;
        end
      end
      CALC: begin
        acc_d    = acc_shift;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          p_d     = p_fix;
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          busy_d  = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      p_q      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      p_q      <= p_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.p    = p_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier at WIDTH=4 and WIDTH=8: drivers queue expected
// products on acceptance, per-instance monitors pop and compare on every done pulse.
module tb_seq_multiplier;

  logic clk;
  logic rst;
  int   cyc;
  int   n_checks;
  int   n_fail;

  logic [7:0]  exp4_q[$];
  logic [15:0] exp8_q[$];
  logic [7:0]  last_p4;
  logic [15:0] last_p8;
  logic        mon_rst4;
  logic        mon_rst8;

  seq_multiplier_if #(.WIDTH(4)) bus4 ();
  seq_multiplier_if #(.WIDTH(8)) bus8 ();

  seq_multiplier #(.WIDTH(4)) dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  seq_multiplier #(.WIDTH(8)) dut8 (
    .clk (clk),
    .rst (rst),
    .bus (bus8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor for the 4-bit instance: scoreboard compare on done, hold check otherwise.
  always @(posedge clk) begin
    mon_rst4 = rst;
    #2;
    checkOutput("busy_done_excl4", 16'(bus4.busy & bus4.done), 16'd0);
    if (mon_rst4) begin
      last_p4 = bus4.p;
    end else if (bus4.done) begin
      if (exp4_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL sb4_underflow: got done with p=%0h, expected no done", bus4.p);
      end else begin
        checkOutput("p4", 16'(bus4.p), 16'(exp4_q.pop_front()));
      end
      last_p4 = bus4.p;
    end else begin
      checkOutput("p4_stable", 16'(bus4.p), 16'(last_p4));
    end
  end

  always @(posedge clk) begin
    mon_rst8 = rst;
    #2;
    checkOutput("busy_done_excl8", 16'(bus8.busy & bus8.done), 16'd0);
    if (mon_rst8) begin
      last_p8 = bus8.p;
    end else if (bus8.done) begin
      if (exp8_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL sb8_underflow: got done with p=%0h, expected no done", bus8.p);
      end else begin
        checkOutput("p8", bus8.p, exp8_q.pop_front());
      end
      last_p8 = bus8.p;
    end else begin
      checkOutput("p8_stable", bus8.p, last_p8);
    end
  end

  // One full 4-bit operation issued at the fastest legal rate, with latency checks.
  task automatic applyStimulus(input logic sm, input logic [3:0] av, input logic [3:0] bv,
                               input logic [7:0] expv);
    @(negedge clk);
    bus4.start       = 1'b1;
    bus4.signed_mode = sm;
    bus4.a           = av;
    bus4.b           = bv;
    @(posedge clk);
    #1;
    checkOutput("accept4", 16'(bus4.busy), 16'd1);
    exp4_q.push_back(expv);
    @(negedge clk);
    bus4.start       = 1'b0;
    bus4.signed_mode = ~sm;
    bus4.a           = ~av;
    bus4.b           = ~bv;
    for (int i = 1; i < 4; i++) begin
      @(posedge clk);
      #1;
      checkOutput("busy4_calc", 16'({bus4.busy, bus4.done}), 16'b10);
    end
    @(posedge clk);
    #1;
    checkOutput("done4_lat", 16'({bus4.busy, bus4.done}), 16'b01);
    @(posedge clk);
    #1;
    checkOutput("done4_pulse", 16'({bus4.busy, bus4.done}), 16'b00);
  endtask

  task automatic applyStimulus8(input logic sm, input logic [7:0] av, input logic [7:0] bv,
                                input logic [15:0] expv);
    @(negedge clk);
    bus8.start       = 1'b1;
    bus8.signed_mode = sm;
    bus8.a           = av;
    bus8.b           = bv;
    @(posedge clk);
    #1;
    checkOutput("accept8", 16'(bus8.busy), 16'd1);
    exp8_q.push_back(expv);
    @(negedge clk);
    bus8.start = 1'b0;
    bus8.a     = 8'h00;
    bus8.b     = 8'h00;
    repeat (7) @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("done8_lat", 16'({bus8.busy, bus8.done}), 16'b01);
    @(posedge clk);
    #1;
    checkOutput("done8_pulse", 16'({bus8.busy, bus8.done}), 16'b00);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int t0, d1, d2, ndone, x;
    logic [3:0] av, bv;
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus4.start = 1'b0; bus4.signed_mode = 1'b0; bus4.a = '0; bus4.b = '0;
    bus8.start = 1'b0; bus8.signed_mode = 1'b0; bus8.a = '0; bus8.b = '0;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset4", 16'({bus4.busy, bus4.done, bus4.p}), 16'd0);
    checkOutput("reset8", bus8.p, 16'd0);
    checkOutput("reset8_flags", 16'({bus8.busy, bus8.done}), 16'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] directed 4-bit vectors");
    applyStimulus(1'b0, 4'd15,   4'd15,   8'hE1);
    applyStimulus(1'b1, 4'b1000, 4'b1000, 8'h40);
    applyStimulus(1'b1, 4'd7,    4'b1101, 8'hEB);
    applyStimulus(1'b1, 4'd0,    4'b1011, 8'h00);
    applyStimulus(1'b1, 4'b1111, 4'd1,    8'hFF);

    $display("[TB] start held high with operands changing during CALC");
    @(negedge clk);
    bus4.start = 1'b1; bus4.signed_mode = 1'b0; bus4.a = 4'd3; bus4.b = 4'd5;
    @(posedge clk);
    #1;
    t0 = cyc;
    checkOutput("held_accept", 16'(bus4.busy), 16'd1);
    exp4_q.push_back(8'd15);
    @(negedge clk);
    bus4.a = 4'd9; bus4.b = 4'd7;
    exp4_q.push_back(8'd63);
    ndone = 0; d1 = 0; d2 = 0;
    for (int i = 0; i < 20 && ndone < 2; i++) begin
      @(posedge clk);
      #1;
      if (bus4.done) begin
        if (ndone == 0) d1 = cyc; else d2 = cyc;
        ndone++;
      end
    end
    @(negedge clk);
    bus4.start = 1'b0;
    checkOutput("held_dones", 16'(ndone), 16'd2);
    checkOutput("held_first_lat", 16'(d1 - t0), 16'd4);
    checkOutput("held_period", 16'(d2 - d1), 16'd6);

    $display("[TB] reset on second CALC cycle");
    @(negedge clk);
    bus4.start = 1'b1; bus4.a = 4'd5; bus4.b = 4'd6;
    @(posedge clk);
    #1;
    checkOutput("abort_accept", 16'(bus4.busy), 16'd1);
    @(negedge clk);
    bus4.start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("abort_clear", 16'({bus4.busy, bus4.done, bus4.p}), 16'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      checkOutput("abort_no_done", 16'(bus4.done), 16'd0);
    end
    applyStimulus(1'b0, 4'd5, 4'd6, 8'h1E);

    $display("[TB] exhaustive 4-bit pairs, both modes");
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < 16; i++) begin
        for (int j = 0; j < 16; j++) begin
          av = 4'(i);
          bv = 4'(j);
          if (m == 1) x = int'($signed(av)) * int'($signed(bv));
          else        x = i * j;
          applyStimulus(m[0], av, bv, x[7:0]);
        end
      end
    end

    $display("[TB] directed 8-bit vectors");
    applyStimulus8(1'b0, 8'hFF, 8'hFF, 16'hFE01);
    applyStimulus8(1'b1, 8'h80, 8'h80, 16'h4000);
    applyStimulus8(1'b1, 8'h80, 8'h7F, 16'hC080);
    applyStimulus8(1'b1, 8'hFD, 8'h05, 16'hFFF1);

    repeat (4) @(posedge clk);
    #3;
    checkOutput("sb4_drained", 16'(exp4_q.size()), 16'd0);
    checkOutput("sb8_drained", 16'(exp8_q.size()), 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
